// File: rtl/shifter_pipe.sv
// Pipelined XLEN-bit barrel shifter (SLL/SRL/SRA) with valid/ready handshake and flush.
// Optional rotate-right on op 2'b10 when SHIFTER_ROT_EN is defined.
module shifter_pipe #(
  parameter  int unsigned XLEN   = 32,
  parameter  int unsigned STAGES = 2,
  localparam int unsigned SHW    = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [SHW-1:0]  in_shamt,
  input  logic [XLEN-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_RSV = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [1:0]        op_q    [STAGES];
  logic [1:0]        op_d    [STAGES];
  logic [SHW-1:0]    shamt_q [STAGES];
  logic [SHW-1:0]    shamt_d [STAGES];
  logic [XLEN-1:0]   data_q  [STAGES];
  logic [XLEN-1:0]   data_d  [STAGES];

  logic [STAGES-1:0] src_valid;
  logic [1:0]        src_op    [STAGES];
  logic [SHW-1:0]    src_shamt [STAGES];
  logic [XLEN-1:0]   src_data  [STAGES];
  logic [XLEN-1:0]   stage_res [STAGES];
  logic [STAGES-1:0] drain;
  logic [STAGES-1:0] load_en;

  // One shift level by amt; SRA fill is the MSB, which no SRA level ever changes.
  function automatic logic [XLEN-1:0] shift_level(input logic [XLEN-1:0] d,
                                                  input logic [1:0]      op,
                                                  input int unsigned     amt);
    logic [XLEN-1:0] r;
    case (op)
      OP_SLL:  r = d << amt;
      OP_SRL:  r = d >> amt;
      OP_SRA:  r = XLEN'($signed(d) >>> amt);
`ifdef SHIFTER_ROT_EN
      default: r = (d >> amt) | (d << (XLEN - amt));
`else
      default: r = '0;
`endif
    endcase
    return r;
  endfunction

  // Stage sources: stage 0 reads the ports, later stages read the previous register.
  always_comb begin
    src_valid    = '0;
    src_valid[0] = in_valid;
    src_op[0]    = in_op;
    src_shamt[0] = in_shamt;
`ifdef SHIFTER_ROT_EN
    src_data[0]  = in_data;
`else
    src_data[0]  = (in_op == OP_RSV) ? '0 : in_data;
`endif
    for (int unsigned j = 1; j < STAGES; j++) begin
      src_valid[j] = valid_q[j-1];
      src_op[j]    = op_q[j-1];
      src_shamt[j] = shamt_q[j-1];
      src_data[j]  = data_q[j-1];
    end
  end

  // Level k is evaluated in stage floor(k*STAGES/SHW).
  always_comb begin
    for (int unsigned j = 0; j < STAGES; j++) begin
      stage_res[j] = src_data[j];
      for (int unsigned k = 0; k < SHW; k++) begin
        if (((k * STAGES) / SHW) == j && src_shamt[j][k]) begin
          stage_res[j] = shift_level(stage_res[j], src_op[j], 32'd1 << k);
        end
      end
    end
  end

  // Backpressure chain: a stage can load when empty or when its content moves on.
  always_comb begin
    drain[STAGES-1] = out_ready;
    for (int i = int'(STAGES) - 2; i >= 0; i--) begin
      drain[i] = !valid_q[i+1] | drain[i+1];
    end
    load_en = ~valid_q | drain;
  end

  assign in_ready  = load_en[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];

  always_comb begin
    valid_d = valid_q;
    for (int unsigned i = 0; i < STAGES; i++) begin
      op_d[i]    = op_q[i];
      shamt_d[i] = shamt_q[i];
      data_d[i]  = data_q[i];
      if (load_en[i]) begin
        valid_d[i] = src_valid[i];
        if (src_valid[i]) begin
          op_d[i]    = src_op[i];
          shamt_d[i] = src_shamt[i];
          data_d[i]  = stage_res[i];
        end
      end
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        op_q[i]    <= '0;
        shamt_q[i] <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned i = 0; i < STAGES; i++) begin
        op_q[i]    <= op_d[i];
        shamt_q[i] <= shamt_d[i];
        data_q[i]  <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe: directed vectors in, monitor pops and compares results.
module tb_shifter_pipe;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned STAGES = 2;
  localparam int unsigned SHW    = $clog2(XLEN);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [SHW-1:0]  in_shamt;
  logic [XLEN-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;

  shifter_pipe #(.XLEN(XLEN), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_shamt(in_shamt), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] data;
    int              cyc;
    bit              lat;
  } exp_t;

  exp_t            sb[$];
  int              cyc = 0;
  int              checks = 0;
  int              failures = 0;
  bit              held_valid = 1'b0;
  logic [XLEN-1:0] held_data = '0;
  bit              saw_not_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: stability while stalled, then pop and compare on each output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held_valid = 1'b0;
    end else if (out_valid) begin
      if (held_valid) chk("stall_stable", out_data, held_data);
      if (out_ready) begin
        held_valid = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got 0x%08h expected no result", out_data);
        end else begin
          e = sb.pop_front();
          chk("result", out_data, e.data);
          if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'(STAGES));
        end
      end else begin
        held_valid = 1'b1;
        held_data  = out_data;
      end
    end else begin
      held_valid = 1'b0;
    end
  end

  // Present one op; called at posedge+1, returns at posedge+1 after it is taken.
  task automatic send(input logic [1:0] op, input int unsigned sh, input logic [31:0] d,
                      input logic [31:0] exp, input bit lat, input bit fl);
    exp_t e;
    int   n = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_shamt = SHW'(sh);
    in_data  = d;
    flush    = fl;
    forever begin
      @(negedge clk);
      if (in_ready || fl) break;
      saw_not_ready = 1'b1;
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: got in_ready=0 expected in_ready=1");
        break;
      end
    end
    if (!fl && in_ready) begin
      e.data = exp;
      e.cyc  = cyc;
      e.lat  = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    logic [31:0] rot_exp;
    logic [31:0] rot0_exp;
`ifdef SHIFTER_ROT_EN
    rot_exp  = 32'h7812_3456;
    rot0_exp = 32'hDEAD_BEEF;
`else
    rot_exp  = 32'h0000_0000;
    rot0_exp = 32'h0000_0000;
`endif
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
    in_shamt = '0; in_data = '0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed single ops, pipe drained between them to measure latency
    send(2'b00, 31, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0); wait_empty();
    send(2'b11,  4, 32'h8000_00F0, 32'hF800_000F, 1'b1, 1'b0); wait_empty();
    send(2'b01,  4, 32'h8000_00F0, 32'h0800_000F, 1'b1, 1'b0); wait_empty();
    send(2'b11,  0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0); wait_empty();
    send(2'b10,  8, 32'h1234_5678, rot_exp,       1'b1, 1'b0); wait_empty();

    // Back-to-back boundary vectors
    send(2'b00,  4, 32'hDEAD_BEEF, 32'hEADB_EEF0, 1'b0, 1'b0);
    send(2'b11, 31, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
    send(2'b11, 31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    send(2'b01, 31, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
    send(2'b10,  0, 32'hDEAD_BEEF, rot0_exp,      1'b0, 1'b0);
    send(2'b01,  0, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 1'b0);
    wait_empty();

    // Stream of 8 with out_ready low for cycles 3-5
    saw_not_ready = 1'b0;
    fork
      for (int i = 0; i < 8; i++) send(2'b00, i, 32'h0000_0001, 32'd1 << i, 1'b0, 1'b0);
      begin
        out_ready = 1'b1;
        idle(3);
        out_ready = 1'b0;
        idle(3);
        out_ready = 1'b1;
      end
    join
    wait_empty();
    chk("in_ready_dropped", 32'(saw_not_ready), 32'd1);

    // Flush with ops in flight plus one presented on the flush cycle
    out_ready = 1'b0;
    send(2'b00, 1, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    if (STAGES >= 2) send(2'b00, 2, 32'h0000_0001, 32'h0000_0004, 1'b0, 1'b0);
    send(2'b00, 3, 32'h0000_0001, 32'h0000_0008, 1'b0, 1'b1);
    sb.delete();
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    idle(int'(STAGES) + 3);

    // Asynchronous reset while a result is held at the output
    out_ready = 1'b0;
    send(2'b01, 8, 32'hFF00_0000, 32'h00FF_0000, 1'b0, 1'b0);
    idle(int'(STAGES) + 1);
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 32'(out_valid), 32'd0);
    chk("async_reset_out_data", out_data, 32'd0);
    sb.delete();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'b11, 16, 32'h8765_4321, 32'hFFFF_8765, 1'b1, 1'b0);
    wait_empty();
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
